xalu_hilo_ctrl: RTL and testbench

- Downstream consumer of the XALU, in EX/MEM.
- Tracks an in-flight mult/multu/div/divu/mul, holds the architectural HI/LO registers, and commits XALU results on completion.
- Hands the mul result to the GPR writeback path through a valid/ready handshake.
- Generates the pipeline stall for mfhi/mflo/mthi/mtlo/new XALU ops while an op is outstanding.

---
 rtl/xalu_pkg.sv | 19 +
 rtl/xalu_hilo_ctrl.sv | 106 ++++++++++
 tb/tb_xalu_hilo_ctrl.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/xalu_pkg.sv
// Shared encodings for the XALU and its HI/LO commit controller.
package xalu_pkg;

    typedef enum logic [1:0] {
        XOP_MULT = 2'b00,
        XOP_DIV  = 2'b01,
        XOP_MUL  = 2'b10,
        XOP_RSVD = 2'b11
    } xop_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_WB   = 2'd2
    } state_e;

    localparam int TIMEOUT_CYC_DEF = 64;

endpackage

// File: rtl/xalu_hilo_ctrl.sv
// Tracks the outstanding XALU op, owns architectural HI/LO, commits results and
// hands mul results to GPR writeback; stalls EX while an op is outstanding.
module xalu_hilo_ctrl
    import xalu_pkg::*;
#(
    parameter int          TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter logic [31:0] HILO_RESET  = 32'h0
) (
    input  logic        Clk,
    input  logic        Clr,
    input  logic        op_start,
    input  logic [1:0]  op_kind,
    input  logic [4:0]  op_dst,
    input  logic        xalu_busy,
    input  logic [31:0] xalu_hi,
    input  logic [31:0] xalu_lo,
    input  logic        mthi_we,
    input  logic        mtlo_we,
    input  logic [31:0] mt_data,
    input  logic        rd_hi_req,
    input  logic        rd_lo_req,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out,
    output logic        stall,
    output logic        gpr_wb_valid,
    output logic [4:0]  gpr_wb_addr,
    output logic [31:0] gpr_wb_data,
    input  logic        gpr_wb_ready,
    output logic        timeout_err
);

    localparam logic [6:0] CNT_LAST = 7'(TIMEOUT_CYC - 1);

    state_e      state;
    xop_e        kind_q;
    logic [4:0]  dst_q;
    logic [6:0]  cnt;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        is_idle;
    logic        any_req;

    assign is_idle = (state == S_IDLE);
    assign any_req = op_start | rd_hi_req | rd_lo_req | mthi_we | mtlo_we;
    assign stall   = !is_idle && any_req;

    // mt writes forward to a same-cycle mfhi/mflo; they only land in IDLE.
    assign hi_out = (mthi_we && is_idle) ? mt_data : hi_q;
    assign lo_out = (mtlo_we && is_idle) ? mt_data : lo_q;

    always_ff @(posedge Clk) begin
        if (Clr) begin
            state        <= S_IDLE;
            kind_q       <= XOP_MULT;
            dst_q        <= 5'd0;
            cnt          <= 7'd0;
            hi_q         <= HILO_RESET;
            lo_q         <= HILO_RESET;
            timeout_err  <= 1'b0;
            gpr_wb_valid <= 1'b0;
            gpr_wb_addr  <= 5'd0;
            gpr_wb_data  <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (mthi_we) hi_q <= mt_data;
                    if (mtlo_we) lo_q <= mt_data;
                    if (op_start && op_kind != XOP_RSVD) begin
                        kind_q <= xop_e'(op_kind);
                        dst_q  <= op_dst;
                        cnt    <= 7'd0;
                        state  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!xalu_busy) begin
                        if (kind_q == XOP_MUL) begin
                            gpr_wb_data  <= xalu_lo;
                            gpr_wb_addr  <= dst_q;
                            gpr_wb_valid <= 1'b1;
                            state        <= S_WB;
                        end else begin
                            hi_q  <= xalu_hi;
                            lo_q  <= xalu_lo;
                            state <= S_IDLE;
                        end
                    end else if (cnt == CNT_LAST) begin
                        // Abandon the op: nothing is committed, the error sticks.
                        timeout_err <= 1'b1;
                        state       <= S_IDLE;
                    end else begin
                        cnt <= cnt + 7'd1;
                    end
                end
                S_WB: begin
                    if (gpr_wb_ready) begin
                        gpr_wb_valid <= 1'b0;
                        state        <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_xalu_hilo_ctrl.sv
// Directed + random bench for xalu_hilo_ctrl against a transaction-level HI/LO model.
module tb_xalu_hilo_ctrl;

    logic        Clk = 1'b0;
    logic        Clr, op_start, xalu_busy, mthi_we, mtlo_we, rd_hi_req, rd_lo_req, gpr_wb_ready;
    logic [1:0]  op_kind;
    logic [4:0]  op_dst;
    logic [31:0] xalu_hi, xalu_lo, mt_data;

    logic [31:0] hi_out, lo_out, gpr_wb_data;
    logic        stall, gpr_wb_valid, timeout_err;
    logic [4:0]  gpr_wb_addr;

    logic [31:0] hi_out8, lo_out8, gpr_wb_data8;
    logic        stall8, gpr_wb_valid8, timeout_err8;
    logic [4:0]  gpr_wb_addr8;

    always #5 Clk = ~Clk;

    xalu_hilo_ctrl dut (
        .Clk(Clk), .Clr(Clr), .op_start(op_start), .op_kind(op_kind), .op_dst(op_dst),
        .xalu_busy(xalu_busy), .xalu_hi(xalu_hi), .xalu_lo(xalu_lo),
        .mthi_we(mthi_we), .mtlo_we(mtlo_we), .mt_data(mt_data),
        .rd_hi_req(rd_hi_req), .rd_lo_req(rd_lo_req), .hi_out(hi_out), .lo_out(lo_out),
        .stall(stall), .gpr_wb_valid(gpr_wb_valid), .gpr_wb_addr(gpr_wb_addr),
        .gpr_wb_data(gpr_wb_data), .gpr_wb_ready(gpr_wb_ready), .timeout_err(timeout_err)
    );

    // Short-timeout instance; only checked in the timeout scenario.
    xalu_hilo_ctrl #(.TIMEOUT_CYC(8)) dut8 (
        .Clk(Clk), .Clr(Clr), .op_start(op_start), .op_kind(op_kind), .op_dst(op_dst),
        .xalu_busy(xalu_busy), .xalu_hi(xalu_hi), .xalu_lo(xalu_lo),
        .mthi_we(mthi_we), .mtlo_we(mtlo_we), .mt_data(mt_data),
        .rd_hi_req(rd_hi_req), .rd_lo_req(rd_lo_req), .hi_out(hi_out8), .lo_out(lo_out8),
        .stall(stall8), .gpr_wb_valid(gpr_wb_valid8), .gpr_wb_addr(gpr_wb_addr8),
        .gpr_wb_data(gpr_wb_data8), .gpr_wb_ready(gpr_wb_ready), .timeout_err(timeout_err8)
    );

    // Reference model: architectural HI/LO plus "op outstanding" / "writeback pending".
    localparam int TO = 64;
    bit          m_pend, m_wbv, m_terr;
    int          m_wait;
    logic [1:0]  m_kind;
    logic [4:0]  m_dst, m_wba;
    logic [31:0] m_hi, m_lo, m_wbd;

    int checks = 0;
    int errors = 0;
    int rem    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic inputs_quiet();
        Clr = 1'b0; op_start = 1'b0; op_kind = 2'b00; op_dst = 5'd0;
        mthi_we = 1'b0; mtlo_we = 1'b0; mt_data = 32'd0;
        rd_hi_req = 1'b0; rd_lo_req = 1'b0; gpr_wb_ready = 1'b0;
    endtask

    // Mid-cycle: compare every observable output of the main instance with the model.
    task automatic settle();
        bit busy_now, any;
        #4;
        busy_now = m_pend || m_wbv;
        any = op_start || rd_hi_req || rd_lo_req || mthi_we || mtlo_we;
        chk("stall", 32'(stall), 32'(busy_now && any));
        chk("hi_out", hi_out, (!busy_now && mthi_we) ? mt_data : m_hi);
        chk("lo_out", lo_out, (!busy_now && mtlo_we) ? mt_data : m_lo);
        chk("wb_valid", 32'(gpr_wb_valid), 32'(m_wbv));
        chk("wb_addr", 32'(gpr_wb_addr), 32'(m_wba));
        chk("wb_data", gpr_wb_data, m_wbd);
        chk("timeout_err", 32'(timeout_err), 32'(m_terr));
    endtask

    task automatic tick();
        if (Clr) begin
            m_pend = 0; m_wbv = 0; m_terr = 0; m_wait = 0;
            m_hi = 32'd0; m_lo = 32'd0; m_wba = 5'd0; m_wbd = 32'd0;
        end else if (!m_pend && !m_wbv) begin
            if (mthi_we) m_hi = mt_data;
            if (mtlo_we) m_lo = mt_data;
            if (op_start && op_kind != 2'b11) begin
                m_pend = 1; m_kind = op_kind; m_dst = op_dst; m_wait = 0;
            end
        end else if (m_pend) begin
            if (!xalu_busy) begin
                m_pend = 0;
                if (m_kind == 2'b10) begin
                    m_wbv = 1; m_wba = m_dst; m_wbd = xalu_lo;
                end else begin
                    m_hi = xalu_hi; m_lo = xalu_lo;
                end
            end else if (m_wait == TO - 1) begin
                m_pend = 0; m_terr = 1;
            end else begin
                m_wait++;
            end
        end else if (gpr_wb_ready) begin
            m_wbv = 0;
        end
        @(posedge Clk);
        #1;
    endtask

    initial begin
        inputs_quiet();
        xalu_busy = 1'b0; xalu_hi = 32'd0; xalu_lo = 32'd0;
        Clr = 1'b1;
        @(posedge Clk);
        #1;
        tick();

        // Reset state, then mthi with same-cycle mfhi.
        Clr = 1'b0;
        settle();
        chk("rst_hi", hi_out, 32'h0);
        chk("rst_lo", lo_out, 32'h0);
        chk("rst_valid", 32'(gpr_wb_valid), 32'h0);
        mthi_we = 1'b1; mt_data = 32'h1234_5678; rd_hi_req = 1'b1;
        settle();
        chk("mthi_bypass", hi_out, 32'h1234_5678);
        chk("mthi_stall", 32'(stall), 32'h0);
        tick();
        inputs_quiet(); rd_hi_req = 1'b1;
        settle();
        chk("mthi_hold", hi_out, 32'h1234_5678);
        chk("mthi_stall2", 32'(stall), 32'h0);
        tick();

        // div: busy t+1..t+33, mflo raised at t+5.
        inputs_quiet(); op_start = 1'b1; op_kind = 2'b01;
        settle(); tick();
        for (int k = 1; k <= 35; k++) begin
            inputs_quiet();
            xalu_busy = (k <= 33);
            if (k == 34) begin xalu_hi = 32'hBEEF_0002; xalu_lo = 32'hCAFE_0001; end
            rd_lo_req = (k >= 5);
            settle();
            if (k >= 5 && k <= 34) chk("div_stall", 32'(stall), 32'h1);
            if (k == 35) begin
                chk("div_stall_end", 32'(stall), 32'h0);
                chk("div_lo", lo_out, 32'hCAFE_0001);
                chk("div_hi", hi_out, 32'hBEEF_0002);
            end
            tick();
        end

        // mul to GPR 9 with a slow consumer.
        inputs_quiet(); op_start = 1'b1; op_kind = 2'b10; op_dst = 5'd9;
        settle(); tick();
        inputs_quiet(); xalu_busy = 1'b1;
        settle(); tick();
        xalu_busy = 1'b0; xalu_lo = 32'hFFFF_FFF6; xalu_hi = 32'h0BAD_0BAD;
        settle(); tick();
        for (int k = 0; k < 4; k++) begin
            gpr_wb_ready = (k == 3);
            xalu_lo = $urandom;
            settle();
            chk("mul_valid", 32'(gpr_wb_valid), 32'h1);
            chk("mul_addr", 32'(gpr_wb_addr), 32'd9);
            chk("mul_data", gpr_wb_data, 32'hFFFF_FFF6);
            chk("mul_hi", hi_out, 32'hBEEF_0002);
            chk("mul_lo", lo_out, 32'hCAFE_0001);
            tick();
        end
        inputs_quiet();
        settle();
        chk("mul_done", 32'(gpr_wb_valid), 32'h0);
        tick();

        // mtlo together with mult in the same IDLE cycle.
        mtlo_we = 1'b1; mt_data = 32'h0000_1111; op_start = 1'b1; op_kind = 2'b00;
        settle(); tick();
        inputs_quiet(); xalu_busy = 1'b0; xalu_lo = 32'h0000_2222; xalu_hi = 32'h0000_3333;
        settle();
        chk("mt_op_lo1", lo_out, 32'h0000_1111);
        tick();
        settle();
        chk("mt_op_lo2", lo_out, 32'h0000_2222);
        chk("mt_op_hi2", hi_out, 32'h0000_3333);
        tick();

        // Timeout on the 8-cycle instance (both instances reset first).
        Clr = 1'b1; settle(); tick();
        inputs_quiet(); mthi_we = 1'b1; mt_data = 32'hA5A5_0000;
        settle(); tick();
        inputs_quiet(); op_start = 1'b1; op_kind = 2'b00;
        settle(); tick();
        inputs_quiet(); xalu_busy = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            settle();
            chk("to_pre", 32'(timeout_err8), 32'h0);
            tick();
        end
        settle();
        chk("to_err", 32'(timeout_err8), 32'h1);
        chk("to_hi", hi_out8, 32'hA5A5_0000);
        chk("to_lo", lo_out8, 32'h0);
        tick();
        mthi_we = 1'b1; mt_data = 32'h0000_0077;
        settle();
        chk("to_mthi_stall", 32'(stall8), 32'h0);
        tick();
        inputs_quiet();
        settle();
        chk("to_mthi_hi", hi_out8, 32'h0000_0077);
        chk("to_sticky", 32'(timeout_err8), 32'h1);
        tick();
        xalu_busy = 1'b0;
        settle(); tick();
        settle(); tick();

        // Clr mid-WAIT, busy drops afterwards: nothing may commit.
        op_start = 1'b1; op_kind = 2'b00;
        settle(); tick();
        inputs_quiet(); xalu_busy = 1'b1;
        for (int k = 0; k < 3; k++) begin settle(); tick(); end
        Clr = 1'b1;
        settle(); tick();
        inputs_quiet(); xalu_busy = 1'b0; xalu_hi = 32'hDEAD_0001; xalu_lo = 32'hDEAD_0002;
        rd_hi_req = 1'b1;
        settle();
        chk("clr_stall", 32'(stall), 32'h0);
        chk("clr_valid", 32'(gpr_wb_valid), 32'h0);
        tick();
        settle();
        chk("clr_hi", hi_out, 32'h0);
        chk("clr_lo", lo_out, 32'h0);
        tick();

        // Random traffic; the bench plays the XALU with 1..20 busy cycles per op.
        rem = 0;
        for (int n = 0; n < 600; n++) begin
            inputs_quiet();
            xalu_busy = (rem > 0);
            if (rem > 0) rem--;
            xalu_hi = $urandom; xalu_lo = $urandom; mt_data = $urandom;
            Clr = ($urandom_range(0, 63) == 0);
            op_start = ($urandom_range(0, 2) == 0);
            op_kind = 2'($urandom_range(0, 3));
            op_dst = 5'($urandom);
            mthi_we = ($urandom_range(0, 4) == 0);
            mtlo_we = ($urandom_range(0, 4) == 0);
            rd_hi_req = ($urandom_range(0, 3) == 0);
            rd_lo_req = ($urandom_range(0, 3) == 0);
            gpr_wb_ready = $urandom_range(0, 1) == 1;
            if (Clr) rem = 0;
            else if (!m_pend && !m_wbv && op_start && op_kind != 2'b11) rem = $urandom_range(1, 20);
            settle();
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
